// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module : decode_stage
// Brief  : RV32I decode stage. Decodes fields, format, immediate and legality
//          of instructions from fetch and hands them to execute over a
//          valid/ready handshake using a registered output stage plus a
//          one-entry skid buffer, so if_ready_o is a pure flop output.
// Rev    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_inst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [6:0]      ex_opcode_o,
  output logic [4:0]      ex_rd_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [2:0]      ex_funct3_o,
  output logic [6:0]      ex_funct7_o,
  output logic [2:0]      ex_fmt_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic            ex_rd_we_o,
  output logic            ex_rs1_used_o,
  output logic            ex_rs2_used_o,
  output logic            ex_illegal_o
);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_MISC   = 7'h0F;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  dec_t        dec;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [2:0]  fmt;
  logic [31:0] imm32;
  logic        bad;

  state_e state_q, state_d;
  dec_t   main_q, main_d;
  dec_t   skid_q, skid_d;
  logic   ready_q;
  logic   accept;
  logic   issue;

  assign op = if_inst_i[6:0];
  assign f3 = if_inst_i[14:12];
  assign f7 = if_inst_i[31:25];

  // Classify the incoming instruction: format, legality, immediate, operand usage
  always_comb begin
    fmt   = FMT_R;
    bad   = 1'b0;
    imm32 = '0;
    dec   = '0;

    // Opcodes whose low two bits are not 2'b11 never match and fall to default
    case (op)
      OPC_LOAD:   begin fmt = FMT_I; bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7); end
      OPC_MISC:   fmt = FMT_I;
      OPC_IMM:    begin
                    fmt = FMT_I;
                    if (f3 == 3'd1)      bad = (f7 != 7'h00);
                    else if (f3 == 3'd5) bad = (f7 != 7'h00) && (f7 != 7'h20);
                  end
      OPC_AUIPC:  fmt = FMT_U;
      OPC_STORE:  begin fmt = FMT_S; bad = (f3 > 3'd2); end
      OPC_OP:     begin
                    fmt = FMT_R;
                    bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
                  end
      OPC_LUI:    fmt = FMT_U;
      OPC_BRANCH: begin fmt = FMT_B; bad = (f3 == 3'd2) || (f3 == 3'd3); end
      OPC_JALR:   begin fmt = FMT_I; bad = (f3 != 3'd0); end
      OPC_JAL:    fmt = FMT_J;
      OPC_SYSTEM: fmt = FMT_I;
      default:    bad = 1'b1;
    endcase

    case (fmt)
      FMT_I:   imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:20]};
      FMT_S:   imm32 = {{20{if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
      FMT_B:   imm32 = {{19{if_inst_i[31]}}, if_inst_i[31], if_inst_i[7],
                        if_inst_i[30:25], if_inst_i[11:8], 1'b0};
      FMT_U:   imm32 = {if_inst_i[31:12], 12'b0};
      FMT_J:   imm32 = {{11{if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12],
                        if_inst_i[20], if_inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    dec.pc      = if_pc_i;
    dec.opcode  = op;
    dec.rd      = if_inst_i[11:7];
    dec.rs1     = if_inst_i[19:15];
    dec.rs2     = if_inst_i[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.fmt     = fmt;
    dec.imm     = XLEN'($signed(imm32));
    dec.illegal = bad;

    // FENCE and ECALL/EBREAK carry an I layout but read no register
    dec.rs1_used = !bad && (fmt != FMT_U) && (fmt != FMT_J) && (op != OPC_MISC) &&
                   !((op == OPC_SYSTEM) && (f3 == 3'd0));
    dec.rs2_used = !bad && ((fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B));
    dec.rd_we    = !bad && (fmt != FMT_S) && (fmt != FMT_B) && (if_inst_i[11:7] != 5'd0);
  end

  assign accept = if_valid_i & ready_q;
  assign issue  = (state_q != S_EMPTY) & ex_ready_i;

  // Occupancy control: main register feeds execute, skid catches one extra
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
                   state_d = S_ONE;
                   main_d  = dec;
                 end
        S_ONE:   if (accept && issue) begin
                   main_d = dec;
                 end else if (accept) begin
                   state_d = S_TWO;
                   skid_d  = dec;
                 end else if (issue) begin
                   state_d = S_EMPTY;
                 end
        S_TWO:   if (issue) begin
                   state_d = S_ONE;
                   main_d  = skid_q;
                 end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State, payload and registered ready; ready drops only while the skid is full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != S_TWO);
    end
  end

  assign if_ready_o    = ready_q;
  assign ex_valid_o    = (state_q != S_EMPTY);
  assign ex_pc_o       = main_q.pc;
  assign ex_opcode_o   = main_q.opcode;
  assign ex_rd_o       = main_q.rd;
  assign ex_rs1_o      = main_q.rs1;
  assign ex_rs2_o      = main_q.rs2;
  assign ex_funct3_o   = main_q.funct3;
  assign ex_funct7_o   = main_q.funct7;
  assign ex_fmt_o      = main_q.fmt;
  assign ex_imm_o      = main_q.imm;
  assign ex_rd_we_o    = main_q.rd_we;
  assign ex_rs1_used_o = main_q.rs1_used;
  assign ex_rs2_used_o = main_q.rs2_used;
  assign ex_illegal_o  = main_q.illegal;

endmodule
`default_nettype wire
